// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Holds the main-FSM state encoding, opcode constants, ALU/immediate codes,
// the per-state control word, and the helper functions used by the FSM and
// the top-level decoders.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   typedef struct packed {
      logic       pcupdate;
      logic       branch;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic       regwrite;
      logic [1:0] aluop;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Only beq is a branch unless bne decoding is enabled.
   function automatic logic op_legal(input logic [6:0] op, input logic [2:0] funct3,
                                     input logic en_bne);
      logic ok;
      ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) || (op == OP_JAL);
      if (op == OP_BRANCH)
         ok = (funct3 == 3'b000) || (en_bne && (funct3 == 3'b001));
      return ok;
   endfunction

   function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                         input logic [2:0] funct3, input logic en_bne);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH:    n = S_DECODE;
         S_DECODE: begin
            if (!op_legal(op, funct3, en_bne)) n = S_FETCH;
            else if (op == OP_LW || op == OP_SW) n = S_MEMADR;
            else if (op == OP_R)                 n = S_EXECR;
            else if (op == OP_I)                 n = S_EXECI;
            else if (op == OP_JAL)               n = S_JAL;
            else                                 n = S_BEQ;
         end
         S_MEMADR:   n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  n = S_MEMWB;
         S_EXECR:    n = S_ALUWB;
         S_EXECI:    n = S_ALUWB;
         S_JAL:      n = S_ALUWB;
         default:    n = S_FETCH;
      endcase
      return n;
   endfunction

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.irwrite = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.pcupdate = 1'b1;
         end
         S_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
         S_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
         S_MEMREAD:  c.adrsrc = 1'b1;
         S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
         S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
         S_EXECR:    begin c.alusrca = 2'b10; c.aluop = ALUOP_FUNC; end
         S_ALUWB:    c.regwrite = 1'b1;
         S_EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = ALUOP_FUNC; end
         S_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
         S_BEQ:      begin c.alusrca = 2'b10; c.aluop = ALUOP_SUB; c.branch = 1'b1; end
         default:    c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_main_fsm.sv
// Main sequencing FSM of the multicycle controller.
// The control word is registered together with the state: on every edge both
// are loaded from the next state, so ctrl always matches state.
//   state    | meaning
//   FETCH    | read instr at PC, IR<=mem, PC<=PC+4
//   DECODE   | read regs, ALUOut<=OldPC+imm (branch/jal target)
//   MEMADR   | ALUOut<=RD1+imm
//   MEMREAD  | read data memory at ALUOut
//   MEMWB    | rd<=Data
//   MEMWRITE | write data memory at ALUOut
//   EXECR    | ALUOut<=RD1 op RD2
//   ALUWB    | rd<=ALUOut
//   EXECI    | ALUOut<=RD1 op imm
//   JAL      | PC<=target, ALUOut<=OldPC+4
//   BEQ      | compare, PC<=target when taken
// Ports: clk, reset (sync, active low), op, funct3 -> state, ctrl (packed ctrl_t).
import mc_ctrl_pkg::*;

module mc_main_fsm #(
   parameter bit EN_BNE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        op,
   input  logic [2:0]        funct3,
   output logic [3:0]        state,
   output logic [CTRL_W-1:0] ctrl
);

   state_t cur;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur  <= S_FETCH;
         ctrl <= state_ctrl(S_FETCH);
      end else begin
         cur  <= next_state(cur, op, funct3, EN_BNE);
         ctrl <= state_ctrl(next_state(cur, op, funct3, EN_BNE));
      end
   end

   assign state = cur;

endmodule

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I core.
// Wraps the main FSM and adds the combinational ALU-control and immediate
// decoders plus the branch/PC-write logic.
// Inputs:  clk, reset (sync, active low), op, funct3, funct7b5, Zero
// Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//          RegWrite, ImmSrc, ALUControl, illegal, fsm_state
import mc_ctrl_pkg::*;

module multicycle_controller #(
   parameter int unsigned ALUCTRL_W = 3,
   parameter bit          EN_BNE    = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 Zero,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic                 RegWrite,
   output logic [1:0]           ImmSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 illegal,
   output logic [3:0]           fsm_state
);

   logic [CTRL_W-1:0] ctrl_bits;
   ctrl_t             c;
   logic              bne_sel;
   logic [2:0]        alu_code;

   mc_main_fsm #(.EN_BNE(EN_BNE)) u_fsm (
      .clk    (clk),
      .reset  (reset),
      .op     (op),
      .funct3 (funct3),
      .state  (fsm_state),
      .ctrl   (ctrl_bits)
   );

   assign c = ctrl_t'(ctrl_bits);

   // bne inverts the sense of Zero; only reachable when bne decoding is on.
   assign bne_sel = EN_BNE && (funct3 == 3'b001);

   // Write strobes are masked while reset is held so an aborted instruction
   // cannot disturb architectural state.
   assign PCWrite   = reset & (c.pcupdate | (c.branch & (Zero ^ bne_sel)));
   assign IRWrite   = reset & c.irwrite;
   assign MemWrite  = reset & c.memwrite;
   assign RegWrite  = reset & c.regwrite;
   assign AdrSrc    = c.adrsrc;
   assign ResultSrc = c.resultsrc;
   assign ALUSrcA   = c.alusrca;
   assign ALUSrcB   = c.alusrcb;

   assign illegal = reset && (fsm_state == S_DECODE) && !op_legal(op, funct3, EN_BNE);

   always_comb begin
      alu_code = ALU_ADD;
      case (c.aluop)
         ALUOP_SUB: alu_code = ALU_SUB;
         ALUOP_FUNC: begin
            case (funct3)
               3'b000:  alu_code = ({op[5], funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_code = ALU_SLT;
               3'b110:  alu_code = ALU_OR;
               3'b111:  alu_code = ALU_AND;
               default: alu_code = ALU_ADD;
            endcase
         end
         default: alu_code = ALU_ADD;
      endcase
   end

   assign ALUControl = ALUCTRL_W'(alu_code);

   always_comb begin
      ImmSrc = IMM_I;
      case (op)
         OP_SW:     ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         default:   ImmSrc = IMM_I;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   localparam int LW  = 'b0000011;
   localparam int SW  = 'b0100011;
   localparam int RT  = 'b0110011;
   localparam int IT  = 'b0010011;
   localparam int JAL = 'b1101111;
   localparam int BR  = 'b1100011;
   localparam int ILL = 'b1111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] fsm_state;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        z;
      logic [20:0] exp;
   } row_t;

   row_t rows[$];

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .RegWrite   (RegWrite),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .illegal    (illegal),
      .fsm_state  (fsm_state)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] observed();
      return {fsm_state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
              ALUSrcB, RegWrite, ImmSrc, ALUControl, illegal};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Row fields: reset, op, funct3, funct7b5, Zero | expected state, PCWrite,
   // AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ImmSrc,
   // ALUControl, illegal.
   task automatic add_row(input int rst, input int o, input int f3, input int f7, input int z,
                          input int st, input int pcw, input int adr, input int mw,
                          input int irw, input int rs, input int a, input int b,
                          input int rw, input int imm, input int alu, input int ill);
      row_t r;
      r.rst = 1'(rst);
      r.op  = 7'(o);
      r.f3  = 3'(f3);
      r.f7  = 1'(f7);
      r.z   = 1'(z);
      r.exp = {4'(st), 1'(pcw), 1'(adr), 1'(mw), 1'(irw), 2'(rs), 2'(a), 2'(b),
               1'(rw), 2'(imm), 3'(alu), 1'(ill)};
      rows.push_back(r);
   endtask

   // Runs one instruction from FETCH back to FETCH and reports the cycle count
   // plus how many cycles each write strobe was high.
   task automatic run_cpi(input string name, input int o, input int f3, input int f7,
                          input int z, input int exp_cyc, input int exp_pcw,
                          input int exp_mw, input int exp_rw);
      int guard, cyc, pcw, mw, rw;
      reset = 1'b1; op = 7'(o); funct3 = 3'(f3); funct7b5 = 1'(f7); Zero = 1'(z);
      guard = 0;
      while (fsm_state != 4'd0 && guard < 16) begin
         @(posedge clk); #1; guard++;
      end
      check({name, "_reach_fetch"}, 32'(fsm_state), 32'd0);
      cyc = 0; pcw = 0; mw = 0; rw = 0;
      do begin
         @(negedge clk);
         pcw += int'(PCWrite); mw += int'(MemWrite); rw += int'(RegWrite);
         @(posedge clk); #1;
         cyc++;
      end while (fsm_state != 4'd0 && cyc < 20);
      check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({name, "_pcwrite_cnt"}, 32'(pcw), 32'(exp_pcw));
      check({name, "_memwrite_cnt"}, 32'(mw), 32'(exp_mw));
      check({name, "_regwrite_cnt"}, 32'(rw), 32'(exp_rw));
   endtask

   initial begin
      reset = 1'b0; op = 7'(LW); funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;

      //       rst op  f3 f7 z  st pcw adr mw irw rs a  b  rw imm alu ill
      add_row(0, LW,  2, 0, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, LW,  2, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, LW,  2, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
      add_row(1, LW,  2, 0, 0,  2, 0, 0, 0, 0,  0, 2, 1, 0, 0, 0, 0);
      add_row(1, LW,  2, 0, 0,  3, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      add_row(1, LW,  2, 0, 0,  4, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
      add_row(1, SW,  2, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 1, 0, 0);
      add_row(1, SW,  2, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0, 0);
      add_row(1, SW,  2, 0, 0,  2, 0, 0, 0, 0,  0, 2, 1, 0, 1, 0, 0);
      add_row(1, SW,  2, 0, 0,  5, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0, 0);
      add_row(1, RT,  0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, RT,  0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
      add_row(1, RT,  0, 1, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 0, 1, 0);
      add_row(1, RT,  0, 1, 0,  7, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
      add_row(1, IT,  0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, IT,  0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
      add_row(1, IT,  0, 1, 0,  8, 0, 0, 0, 0,  0, 2, 1, 0, 0, 0, 0);
      add_row(1, IT,  0, 1, 0,  7, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
      add_row(1, BR,  0, 0, 1,  0, 1, 0, 0, 1,  2, 0, 2, 0, 2, 0, 0);
      add_row(1, BR,  0, 0, 1,  1, 0, 0, 0, 0,  0, 1, 1, 0, 2, 0, 0);
      add_row(1, BR,  0, 0, 1, 10, 1, 0, 0, 0,  0, 2, 0, 0, 2, 1, 0);
      add_row(1, BR,  0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 2, 0, 0);
      add_row(1, BR,  0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 2, 0, 0);
      add_row(1, BR,  0, 0, 0, 10, 0, 0, 0, 0,  0, 2, 0, 0, 2, 1, 0);
      add_row(1, JAL, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 3, 0, 0);
      add_row(1, JAL, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 3, 0, 0);
      add_row(1, JAL, 0, 0, 0,  9, 1, 0, 0, 0,  0, 1, 2, 0, 3, 0, 0);
      add_row(1, JAL, 0, 0, 0,  7, 0, 0, 0, 0,  0, 0, 0, 1, 3, 0, 0);
      add_row(1, ILL, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, ILL, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 1);
      add_row(1, BR,  1, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 2, 0, 0);
      add_row(1, BR,  1, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 2, 0, 1);
      add_row(1, RT,  6, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, RT,  6, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
      add_row(1, RT,  6, 0, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 0, 3, 0);
      add_row(1, RT,  6, 0, 0,  7, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
      add_row(1, IT,  2, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, IT,  2, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
      add_row(1, IT,  2, 0, 0,  8, 0, 0, 0, 0,  0, 2, 1, 0, 0, 5, 0);
      add_row(1, IT,  2, 0, 0,  7, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
      add_row(1, RT,  7, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, RT,  7, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
      add_row(0, RT,  7, 0, 0,  6, 0, 0, 0, 0,  0, 2, 0, 0, 0, 2, 0);
      add_row(0, RT,  7, 0, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, RT,  7, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0, 0, 0);
      add_row(1, RT,  7, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);

      repeat (2) @(posedge clk);

      for (int i = 0; i < rows.size(); i++) begin
         @(posedge clk); #1;
         reset    = rows[i].rst;
         op       = rows[i].op;
         funct3   = rows[i].f3;
         funct7b5 = rows[i].f7;
         Zero     = rows[i].z;
         @(negedge clk);
         check($sformatf("row%0d", i), 32'(observed()), 32'(rows[i].exp));
      end

      run_cpi("cpi_lw",      LW,  2, 0, 0, 5, 1, 0, 1);
      run_cpi("cpi_sw",      SW,  2, 0, 0, 4, 1, 1, 0);
      run_cpi("cpi_r",       RT,  0, 0, 0, 4, 1, 0, 1);
      run_cpi("cpi_beq_t",   BR,  0, 0, 1, 3, 2, 0, 0);
      run_cpi("cpi_beq_nt",  BR,  0, 0, 0, 3, 1, 0, 0);
      run_cpi("cpi_jal",     JAL, 0, 0, 0, 4, 2, 0, 1);
      run_cpi("cpi_illegal", ILL, 0, 0, 0, 2, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
